// File: rtl/mem_access_master_pkg.sv
// Shared widths, latency limits and FSM state encoding for the memory access master.
package mem_access_master_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 8;
   localparam int LEN_W_DEF   = 4;
   localparam int RD_LAT_DEF  = 1;
   localparam int RD_LAT_MAX  = 7;
   localparam int LAT_CNT_W   = 3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WRITE    = 3'd1,
      ST_RD_ISSUE = 3'd2,
      ST_RD_WAIT  = 3'd3,
      ST_RD_RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/mem_access_master_if.sv
// Command, write-stream, read-stream and memory-port signals of the access master.
interface mem_access_master_if
   import mem_access_master_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;

   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;

   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;

   logic              done;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_write_en;
   logic              mem_read_en;
   logic [DATA_W-1:0] mem_data_out;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      output cmd_ready,
      input  wr_valid, wr_data,
      output wr_ready,
      output rd_valid, rd_data, rd_last,
      input  rd_ready,
      output done,
      output mem_address, mem_data_in, mem_write_en, mem_read_en,
      input  mem_data_out
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  cmd_ready,
      output wr_valid, wr_data,
      input  wr_ready,
      input  rd_valid, rd_data, rd_last,
      output rd_ready,
      input  done,
      input  mem_address, mem_data_in, mem_write_en, mem_read_en,
      output mem_data_out
   );

endinterface

// File: rtl/mem_rd_lat_ctr.sv
// Read-latency down-counter: loaded when the read strobe is sampled, flags the capture edge.
module mem_rd_lat_ctr
   import mem_access_master_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [LAT_CNT_W-1:0] load_val,
   output logic                 expired
);

   logic [LAT_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - LAT_CNT_W'(1);
      end
   end

   // Terminal count of 1 means the next edge is RD_LAT edges past the sampling edge.
   assign expired = (cnt == LAT_CNT_W'(1));

endmodule

// File: rtl/mem_access_master.sv
// Burst initiator for the memory_wrapper port: splits valid/ready burst commands into
// single-beat read/write strobes and streams beat data in and out.
//
//  state       | meaning
//  ------------+---------------------------------------------------------------
//  ST_IDLE     | cmd_ready high, waiting for a burst command
//  ST_WRITE    | wr_ready high, each accepted beat becomes one write strobe
//  ST_RD_ISSUE | mem_read_en high for this single cycle at cur_addr
//  ST_RD_WAIT  | counting memory read latency before capturing data_out
//  ST_RD_RESP  | read beat held on rd_* until the consumer takes it
module mem_access_master
   import mem_access_master_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   mem_access_master_if.master bus
);

   localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT);

   state_t            state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [LEN_W-1:0]  beat_cnt;
   logic [LEN_W-1:0]  len_q;
   logic              last_beat;
   logic              lat_load;
   logic              lat_expired;

   assign next_addr = cur_addr + ADDR_W'(1);
   assign last_beat = (beat_cnt == len_q);
   assign lat_load  = (state == ST_RD_ISSUE);

   mem_rd_lat_ctr u_rd_lat_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (lat_load),
      .load_val (LAT_INIT),
      .expired  (lat_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         cur_addr         <= '0;
         beat_cnt         <= '0;
         len_q            <= '0;
         bus.cmd_ready    <= 1'b0;
         bus.wr_ready     <= 1'b0;
         bus.rd_valid     <= 1'b0;
         bus.rd_data      <= '0;
         bus.rd_last      <= 1'b0;
         bus.done         <= 1'b0;
         bus.mem_address  <= '0;
         bus.mem_data_in  <= '0;
         bus.mem_write_en <= 1'b0;
         bus.mem_read_en  <= 1'b0;
      end else begin
         bus.done         <= 1'b0;
         bus.mem_write_en <= 1'b0;
         bus.mem_read_en  <= 1'b0;

         case (state)
            ST_IDLE: begin
               bus.cmd_ready <= 1'b1;
               if (bus.cmd_valid && bus.cmd_ready) begin
                  bus.cmd_ready <= 1'b0;
                  cur_addr      <= bus.cmd_addr;
                  len_q         <= bus.cmd_len;
                  beat_cnt      <= '0;
                  if (bus.cmd_write) begin
                     state        <= ST_WRITE;
                     bus.wr_ready <= 1'b1;
                  end else begin
                     state           <= ST_RD_ISSUE;
                     bus.mem_read_en <= 1'b1;
                     bus.mem_address <= bus.cmd_addr;
                  end
               end
            end

            ST_WRITE: begin
               if (bus.wr_valid && bus.wr_ready) begin
                  bus.mem_write_en <= 1'b1;
                  bus.mem_address  <= cur_addr;
                  bus.mem_data_in  <= bus.wr_data;
                  cur_addr         <= next_addr;
                  beat_cnt         <= beat_cnt + LEN_W'(1);
                  // done lines up with the final write strobe, not a cycle later.
                  if (last_beat) begin
                     state         <= ST_IDLE;
                     bus.wr_ready  <= 1'b0;
                     bus.done      <= 1'b1;
                     bus.cmd_ready <= 1'b1;
                  end
               end
            end

            ST_RD_ISSUE: begin
               // Zero latency means data_out is already valid at the sampling edge.
               if (RD_LAT == 0) begin
                  bus.rd_data  <= bus.mem_data_out;
                  bus.rd_valid <= 1'b1;
                  bus.rd_last  <= last_beat;
                  state        <= ST_RD_RESP;
               end else begin
                  state <= ST_RD_WAIT;
               end
            end

            ST_RD_WAIT: begin
               if (lat_expired) begin
                  bus.rd_data  <= bus.mem_data_out;
                  bus.rd_valid <= 1'b1;
                  bus.rd_last  <= last_beat;
                  state        <= ST_RD_RESP;
               end
            end

            ST_RD_RESP: begin
               if (bus.rd_valid && bus.rd_ready) begin
                  bus.rd_valid <= 1'b0;
                  bus.rd_last  <= 1'b0;
                  if (last_beat) begin
                     state         <= ST_IDLE;
                     bus.done      <= 1'b1;
                     bus.cmd_ready <= 1'b1;
                  end else begin
                     cur_addr        <= next_addr;
                     beat_cnt        <= beat_cnt + LEN_W'(1);
                     bus.mem_read_en <= 1'b1;
                     bus.mem_address <= next_addr;
                     state           <= ST_RD_ISSUE;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master with a behavioural memory_wrapper (registered read, 1 edge).
`timescale 1ns/1ps
module tb_mem_access_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_access_master_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(4)) bus ();

   mem_access_master #(.ADDR_W(8), .DATA_W(8), .LEN_W(4), .RD_LAT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // memory_wrapper stand-in: pattern-filled, synchronous write, registered read.
   logic [7:0] mem [256];
   logic       mem_init_done = 1'b0;
   logic [7:0] mem_q = 8'h00;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
         mem_init_done <= 1'b1;
      end else begin
         if (bus.mem_write_en) mem[bus.mem_address] <= bus.mem_data_in;
         if (bus.mem_read_en) mem_q <= mem[bus.mem_address];
      end
   end
   assign bus.mem_data_out = mem_q;

   // Strobe log, sampled mid-cycle.
   int         wn = 0, rn = 0, dn = 0, collide = 0;
   logic [7:0] wlog_addr [64];
   logic [7:0] wlog_data [64];
   logic       wlog_done [64];
   always @(negedge clk) begin
      if (bus.mem_write_en) begin
         wlog_addr[wn] = bus.mem_address;
         wlog_data[wn] = bus.mem_data_in;
         wlog_done[wn] = bus.done;
         wn = wn + 1;
      end
      if (bus.mem_read_en) rn = rn + 1;
      if (bus.done) dn = dn + 1;
      if (bus.mem_read_en && bus.mem_write_en) collide = collide + 1;
   end

   int checks = 0;
   int fails  = 0;

   task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [3:0] len);
      int n = 0;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!bus.cmd_ready) begin
         fails++;
         $display("FAIL cmd_accept_timeout: cmd_ready stayed %b, required 1", bus.cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_wr_ready();
      int n = 0;
      while (!bus.wr_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!bus.wr_ready) begin
         fails++;
         $display("FAIL wr_ready_timeout: wr_ready stayed %b, required 1", bus.wr_ready);
      end
   endtask

   task automatic wait_rd_valid();
      int n = 0;
      while (!bus.rd_valid && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!bus.rd_valid) begin
         fails++;
         $display("FAIL rd_valid_timeout: rd_valid stayed %b, required 1", bus.rd_valid);
      end
   endtask

   task automatic test_reset();
      logic [30:0] outs;
      repeat (3) @(posedge clk);
      @(negedge clk);
      outs = {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.rd_last, bus.done,
              bus.mem_address, bus.mem_data_in, bus.mem_write_en, bus.mem_read_en};
      checks++;
      if (outs !== 31'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, required 0", outs);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL idle_cmd_ready: got %b, required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_single_write();
      int w0, d0;
      @(negedge clk); #1; w0 = wn; d0 = dn;
      send_cmd(1'b1, 8'h01, 4'd0);
      checks++;
      if (bus.wr_ready !== 1'b1) begin
         fails++;
         $display("FAIL sw_wr_ready: got %b, required 1", bus.wr_ready);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h55;
      @(posedge clk);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      checks++;
      if ({bus.mem_write_en, bus.done, bus.mem_address, bus.mem_data_in, bus.wr_ready} !== {1'b1, 1'b1, 8'h01, 8'h55, 1'b0}) begin
         fails++;
         $display("FAIL sw_strobe: we=%b done=%b addr=%h data=%h wr_ready=%b, required 1 1 01 55 0",
                  bus.mem_write_en, bus.done, bus.mem_address, bus.mem_data_in, bus.wr_ready);
      end
      @(negedge clk);
      checks++;
      if ({bus.mem_write_en, bus.done, bus.cmd_ready, bus.mem_address} !== {1'b0, 1'b0, 1'b1, 8'h01}) begin
         fails++;
         $display("FAIL sw_after: we=%b done=%b cmd_ready=%b addr=%h, required 0 0 1 01",
                  bus.mem_write_en, bus.done, bus.cmd_ready, bus.mem_address);
      end
      repeat (2) @(negedge clk); #1;
      checks++;
      if (wn - w0 != 1 || dn - d0 != 1) begin
         fails++;
         $display("FAIL sw_counts: writes=%0d dones=%0d, required 1 1", wn - w0, dn - d0);
      end
   endtask

   task automatic test_single_read();
      int r0, d0;
      @(negedge clk); #1; r0 = rn; d0 = dn;
      send_cmd(1'b0, 8'h01, 4'd0);
      checks++;
      if (bus.mem_read_en !== 1'b1 || bus.mem_address !== 8'h01) begin
         fails++;
         $display("FAIL sr_issue: re=%b addr=%h, required 1 01", bus.mem_read_en, bus.mem_address);
      end
      wait_rd_valid();
      checks++;
      if ({bus.rd_data, bus.rd_last, bus.done} !== {8'h55, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL sr_beat: data=%h last=%b done=%b, required 55 1 0", bus.rd_data, bus.rd_last, bus.done);
      end
      bus.rd_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rd_ready = 1'b0;
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.done !== 1'b1) begin
         fails++;
         $display("FAIL sr_done: rd_valid=%b done=%b, required 0 1", bus.rd_valid, bus.done);
      end
      repeat (2) @(negedge clk); #1;
      checks++;
      if (rn - r0 != 1 || dn - d0 != 1) begin
         fails++;
         $display("FAIL sr_counts: reads=%0d dones=%0d, required 1 1", rn - r0, dn - d0);
      end
   endtask

   task automatic test_burst_write_gap();
      logic [7:0] exp [4];
      int w0;
      exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'h01;
      @(negedge clk); #1; w0 = wn;
      send_cmd(1'b1, 8'hFE, 4'd3);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            bus.wr_valid = 1'b0;
            repeat (2) @(negedge clk);
         end
         bus.wr_valid = 1'b1;
         bus.wr_data  = exp[i];
         wait_wr_ready();
         @(posedge clk);
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      repeat (3) @(negedge clk); #1;
      checks++;
      if (wn - w0 != 4) begin
         fails++;
         $display("FAIL bw_count: write strobes=%0d, required 4", wn - w0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({wlog_addr[w0+i], wlog_data[w0+i], wlog_done[w0+i]} !== {exp[i], exp[i], (i == 3)}) begin
            fails++;
            $display("FAIL bw_beat%0d: addr=%h data=%h done=%b, required %h %h %b",
                     i, wlog_addr[w0+i], wlog_data[w0+i], wlog_done[w0+i], exp[i], exp[i], (i == 3));
         end
      end
   endtask

   task automatic test_burst_read_stall();
      logic [7:0] exp [4];
      logic [7:0] got;
      int r0, d0;
      exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'h01;
      @(negedge clk); #1; r0 = rn; d0 = dn;
      send_cmd(1'b0, 8'hFE, 4'd3);
      for (int i = 0; i < 4; i++) begin
         wait_rd_valid();
         got = bus.rd_data;
         checks++;
         if (got !== exp[i] || bus.rd_last !== (i == 3)) begin
            fails++;
            $display("FAIL br_beat%0d: data=%h last=%b, required %h %b", i, got, bus.rd_last, exp[i], (i == 3));
         end
         if (i == 0) begin
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               checks++;
               if (bus.rd_valid !== 1'b1 || bus.rd_data !== got) begin
                  fails++;
                  $display("FAIL br_hold%0d: rd_valid=%b data=%h, required 1 %h", s, bus.rd_valid, bus.rd_data, got);
               end
            end
            #1;
            checks++;
            if (rn - r0 != 1) begin
               fails++;
               $display("FAIL br_stall_reads: reads=%0d, required 1", rn - r0);
            end
         end
         bus.rd_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         bus.rd_ready = 1'b0;
      end
      checks++;
      if (bus.done !== 1'b1) begin
         fails++;
         $display("FAIL br_done: done=%b, required 1", bus.done);
      end
      repeat (2) @(negedge clk); #1;
      checks++;
      if (rn - r0 != 4 || dn - d0 != 1) begin
         fails++;
         $display("FAIL br_counts: reads=%0d dones=%0d, required 4 1", rn - r0, dn - d0);
      end
   endtask

   task automatic test_cmd_ignored();
      int w0, r0;
      @(negedge clk); #1; w0 = wn; r0 = rn;
      send_cmd(1'b1, 8'h10, 4'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 8'h80;
      bus.cmd_len   = 4'd5;
      bus.wr_valid  = 1'b1;
      bus.wr_data   = 8'h11;
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL ci_cmd_ready: got %b, required 0", bus.cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.wr_data   = 8'h22;
      @(posedge clk);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      checks++;
      if ({bus.done, bus.mem_address, bus.mem_data_in} !== {1'b1, 8'h11, 8'h22}) begin
         fails++;
         $display("FAIL ci_last: done=%b addr=%h data=%h, required 1 11 22", bus.done, bus.mem_address, bus.mem_data_in);
      end
      repeat (3) @(negedge clk); #1;
      checks++;
      if (wn - w0 != 2 || rn - r0 != 0 || wlog_addr[w0] !== 8'h10 || wlog_data[w0] !== 8'h11) begin
         fails++;
         $display("FAIL ci_counts: writes=%0d reads=%0d first=%h/%h, required 2 0 10/11",
                  wn - w0, rn - r0, wlog_addr[w0], wlog_data[w0]);
      end
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL ci_idle: cmd_ready=%b, required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [30:0] outs;
      int w0, d0;
      @(negedge clk); #1; w0 = wn; d0 = dn;
      send_cmd(1'b1, 8'h20, 4'd3);
      for (int i = 0; i < 2; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 8'hA0 + 8'(i);
         wait_wr_ready();
         @(posedge clk);
         @(negedge clk);
      end
      bus.wr_data = 8'hA2;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      outs = {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_data, bus.rd_last, bus.done,
              bus.mem_address, bus.mem_data_in, bus.mem_write_en, bus.mem_read_en};
      checks++;
      if (outs !== 31'h0) begin
         fails++;
         $display("FAIL rst_mid_outputs: got %h, required 0", outs);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk); #1;
      checks++;
      if (wn - w0 != 2 || dn - d0 != 0) begin
         fails++;
         $display("FAIL rst_mid_counts: writes=%0d dones=%0d, required 2 0", wn - w0, dn - d0);
      end
      send_cmd(1'b0, 8'h22, 4'd0);
      wait_rd_valid();
      checks++;
      if (bus.rd_data !== 8'hE1 || bus.rd_last !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_readback: data=%h last=%b, required E1 1", bus.rd_data, bus.rd_last);
      end
      bus.rd_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rd_ready = 1'b0;
      checks++;
      if (bus.done !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_read_done: done=%b, required 1", bus.done);
      end
   endtask

   task automatic test_no_collision();
      @(negedge clk); #1;
      checks++;
      if (collide != 0) begin
         fails++;
         $display("FAIL strobe_collision: cycles with both strobes=%0d, required 0", collide);
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 8'h00;
      bus.cmd_len   = 4'd0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = 8'h00;
      bus.rd_ready  = 1'b0;
      test_reset();
      test_single_write();
      test_single_read();
      test_burst_write_gap();
      test_burst_read_stall();
      test_cmd_ignored();
      test_reset_mid_burst();
      test_no_collision();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
